// File: rtl/status_bank_pkg.sv
// Shared types and helpers for the status register bank.
package status_bank_pkg;

    // Channel behaviour on write: replace or OR-accumulate.
    typedef enum logic {
        CH_NORMAL = 1'b0,
        CH_STICKY = 1'b1
    } ch_mode_e;

    // Status word layout: New flags start at bit 0, Overrun flags follow them.
    localparam int unsigned STATUS_NEW_LSB = 0;

    function automatic int unsigned status_ovr_lsb(input int unsigned num_ch);
        return num_ch;
    endfunction

    // Word address width covering NUM_CH channels plus the status word.
    function automatic int unsigned addr_width(input int unsigned num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/status_channel.sv
// One status channel: live value, New/Overrun flags and sticky clear handling.
module status_channel
    import status_bank_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter ch_mode_e              MODE        = CH_NORMAL,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clear,
    input  logic                  ovr_clear,
    output logic [DATA_WIDTH-1:0] live,
    output logic                  new_flag,
    output logic                  overrun,
    output logic                  new_next
);

    logic [DATA_WIDTH-1:0] base;

    // A clearing read returns a sticky channel to RESET_VALUE; a same-cycle
    // write then ORs into that cleared value so no written bits are lost.
    always_comb begin
        base     = (MODE == CH_STICKY && rd_clear) ? RESET_VALUE : live;
        new_next = wr_en | (new_flag & ~rd_clear);
    end

    // Live value and flag state; the write always wins over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live     <= RESET_VALUE;
            new_flag <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wr_en) begin
                live <= (MODE == CH_STICKY) ? (base | wr_data) : wr_data;
            end else begin
                live <= base;
            end
            new_flag <= new_next;
            overrun  <= (wr_en & new_flag) | (overrun & ~ovr_clear);
        end
    end

endmodule

// File: rtl/status_register_bank.sv
// Processor-read-only multi-channel status bank with optional coherent snapshot.
module status_register_bank
    import status_bank_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_CH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [NUM_CH-1:0]     STICKY_MASK = '0,
    parameter int unsigned           SNAPSHOT    = 1
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Sys_RegSelect,
    input  logic                           Sys_RdEn,
    input  logic [addr_width(NUM_CH)-1:0]  Sys_Addr,
    output logic [DATA_WIDTH-1:0]          Sys_RdData,
    output logic                           Sys_RdValid,
    input  logic [NUM_CH-1:0]              Sys_IrqMask,
    output logic                           Sys_Irq,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   IO_WrData,
    input  logic [NUM_CH-1:0]              IO_WrEn
);

    localparam int unsigned AW      = addr_width(NUM_CH);
    localparam int unsigned OVR_LSB = status_ovr_lsb(NUM_CH);

    logic [DATA_WIDTH-1:0] live   [NUM_CH];
    logic [DATA_WIDTH-1:0] shadow [NUM_CH];
    logic [NUM_CH-1:0]     new_flags;
    logic [NUM_CH-1:0]     new_next;
    logic [NUM_CH-1:0]     overruns;
    logic [NUM_CH-1:0]     ch_hit;
    logic [NUM_CH-1:0]     rd_clear;
    logic                  status_hit;
    logic                  accept;
    logic                  snap_take;
    logic                  ovr_clear;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] rd_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        status_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (STICKY_MASK[g] ? CH_STICKY : CH_NORMAL),
            .RESET_VALUE(RESET_VALUE)
        ) u_ch (
            .clk      (Clock),
            .rst_n    (Reset),
            .wr_en    (IO_WrEn[g]),
            .wr_data  (IO_WrData[g*DATA_WIDTH +: DATA_WIDTH]),
            .rd_clear (rd_clear[g]),
            .ovr_clear(ovr_clear),
            .live     (live[g]),
            .new_flag (new_flags[g]),
            .overrun  (overruns[g]),
            .new_next (new_next[g])
        );
    end

    // Address decode and the clear strobes a read produces.
    always_comb begin
        accept = Sys_RegSelect & Sys_RdEn;
        ch_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = (Sys_Addr == AW'(i));
        end
        status_hit = (Sys_Addr == AW'(NUM_CH));
        snap_take  = (SNAPSHOT != 0) && accept && ch_hit[0];
        ovr_clear  = accept & status_hit;
        if (SNAPSHOT != 0) begin
            rd_clear = {NUM_CH{snap_take}};
        end else begin
            rd_clear = accept ? ch_hit : '0;
        end
    end

    // Read mux; channel 0 is always live, others come from Shadow in snapshot mode.
    always_comb begin
        status_word = '0;
        status_word[STATUS_NEW_LSB +: NUM_CH] = new_flags;
        status_word[OVR_LSB +: NUM_CH]        = overruns;
        rd_next = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
                rd_next = (SNAPSHOT != 0 && i != 0) ? shadow[i] : live[i];
            end
        end
        if (status_hit) begin
            rd_next = status_word;
        end
    end

    // Snapshot capture of all pre-write live values on a channel 0 read.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= RESET_VALUE;
            end
        end else if (snap_take) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= live[i];
            end
        end
    end

    // Registered read response and interrupt from next-state New flags.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Sys_RdData  <= '0;
            Sys_RdValid <= 1'b0;
            Sys_Irq     <= 1'b0;
        end else begin
            Sys_RdValid <= accept;
            if (accept) begin
                Sys_RdData <= rd_next;
            end
            Sys_Irq <= |(new_next & Sys_IrqMask);
        end
    end

endmodule

// File: tb/tb_status_register_bank.sv
// Self-checking bench: two configurations (live reads, snapshot reads) share stimulus.
module tb_status_register_bank;

    localparam int unsigned NC  = 4;
    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV1 = 32'hA5A5_0000;
    localparam logic [3:0]  STK0 = 4'b0010;
    localparam logic [3:0]  STK1 = 4'b0100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel;
    logic          rden;
    logic [2:0]    addr;
    logic [3:0]    mask;
    logic [127:0]  wdata;
    logic [3:0]    wren;
    logic [1:0][31:0] rd_data;
    logic [1:0]    rd_valid;
    logic [1:0]    irq;

    int tests = 0;
    int fails = 0;

    // Reference model state, indexed [dut][channel]
    logic [31:0] m_live   [2][4];
    logic [31:0] m_shadow [2][4];
    bit          m_new    [2][4];
    bit          m_ovr    [2][4];
    logic [31:0] m_rd     [2];
    bit          m_valid  [2];
    bit          m_irq    [2];

    always #5 clk = ~clk;

    status_register_bank #(
        .DATA_WIDTH(32), .NUM_CH(4), .RESET_VALUE(RV0), .STICKY_MASK(STK0), .SNAPSHOT(0)
    ) dut0 (
        .Clock(clk), .Reset(rst_n), .Sys_RegSelect(sel), .Sys_RdEn(rden), .Sys_Addr(addr),
        .Sys_RdData(rd_data[0]), .Sys_RdValid(rd_valid[0]), .Sys_IrqMask(mask), .Sys_Irq(irq[0]),
        .IO_WrData(wdata), .IO_WrEn(wren)
    );

    status_register_bank #(
        .DATA_WIDTH(32), .NUM_CH(4), .RESET_VALUE(RV1), .STICKY_MASK(STK1), .SNAPSHOT(1)
    ) dut1 (
        .Clock(clk), .Reset(rst_n), .Sys_RegSelect(sel), .Sys_RdEn(rden), .Sys_Addr(addr),
        .Sys_RdData(rd_data[1]), .Sys_RdValid(rd_valid[1]), .Sys_IrqMask(mask), .Sys_Irq(irq[1]),
        .IO_WrData(wdata), .IO_WrEn(wren)
    );

    function automatic bit snap_of(input int d);
        return d == 1;
    endfunction

    function automatic logic [31:0] rv_of(input int d);
        return (d == 0) ? RV0 : RV1;
    endfunction

    function automatic bit sticky_of(input int d, input int i);
        logic [3:0] m;
        m = (d == 0) ? STK0 : STK1;
        return m[i];
    endfunction

    function automatic logic [31:0] model_status(input int d);
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < NC; i++) begin
            if (m_new[d][i]) s += (32'd1 << i);
            if (m_ovr[d][i]) s += (32'd1 << (NC + i));
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NC; i++) begin
                m_live[d][i]   = rv_of(d);
                m_shadow[d][i] = rv_of(d);
                m_new[d][i]    = 0;
                m_ovr[d][i]    = 0;
            end
            m_rd[d]    = 0;
            m_valid[d] = 0;
            m_irq[d]   = 0;
        end
    endtask

    // One clock of behaviour: read sees the pre-edge state, then writes/clears apply.
    task automatic model_step(input int d);
        bit          accepted;
        bit          clr_new [4];
        bit          clr_ovr;
        bit          had_new;
        int          a;
        logic [31:0] data;
        accepted = sel && rden;
        a = int'(addr);
        clr_ovr = accepted && (a == NC);
        for (int i = 0; i < NC; i++) clr_new[i] = 0;
        m_valid[d] = accepted;
        if (accepted) begin
            if (a < NC) begin
                if (snap_of(d) && a != 0) m_rd[d] = m_shadow[d][a];
                else                      m_rd[d] = m_live[d][a];
                if (!snap_of(d)) begin
                    clr_new[a] = 1;
                end else if (a == 0) begin
                    for (int i = 0; i < NC; i++) begin
                        clr_new[i]     = 1;
                        m_shadow[d][i] = m_live[d][i];
                    end
                end
            end else if (a == NC) begin
                m_rd[d] = model_status(d);
            end else begin
                m_rd[d] = 0;
            end
        end
        for (int i = 0; i < NC; i++) begin
            data    = wdata[i*32 +: 32];
            had_new = m_new[d][i];
            if (sticky_of(d, i) && clr_new[i]) m_live[d][i] = rv_of(d);
            if (wren[i]) begin
                m_live[d][i] = sticky_of(d, i) ? (m_live[d][i] | data) : data;
                m_new[d][i]  = 1;
            end else if (clr_new[i]) begin
                m_new[d][i] = 0;
            end
            m_ovr[d][i] = (m_ovr[d][i] && !clr_ovr) || (wren[i] && had_new);
        end
        m_irq[d] = 0;
        for (int i = 0; i < NC; i++) begin
            if (m_new[d][i] && mask[i]) m_irq[d] = 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
    task automatic cycle(input bit s, input bit r, input logic [2:0] a,
                         input logic [3:0] we, input logic [127:0] wd);
        sel = s; rden = r; addr = a; wren = we; wdata = wd;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
    endtask

    task automatic rd(input logic [2:0] a);
        cycle(1'b1, 1'b1, a, 4'b0000, '0);
    endtask

    task automatic wr(input int ch, input logic [31:0] v);
        logic [127:0] wd;
        wd = '0;
        wd[ch*32 +: 32] = v;
        cycle(1'b0, 1'b0, 3'd0, 4'(1 << ch), wd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 3'd0, 4'b0000, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] expv;
        mask = 4'hF;
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 3'd0, 4'b0000, '0);
        cycle(1'b0, 1'b0, 3'd0, 4'b0000, '0);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 3'd0, 4'hF, {4{32'h1234_5678}});
        rst_n = 1'b0;
        cycle(1'b1, 1'b1, 3'd4, 4'hF, {4{32'h0F0F_0F0F}});
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (rd_valid[d] !== 1'b0 || rd_data[d] !== 32'h0 || irq[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_read dut%0d: valid=%b data=%h irq=%b, required 0/0/0",
                         d, rd_valid[d], rd_data[d], irq[d]);
            end
        end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            for (int d = 0; d < 2; d++) begin
                expv = (a < NC) ? rv_of(d) : 32'h0;
                tests++;
                if (rd_data[d] !== expv || rd_valid[d] !== 1'b1 || irq[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_read dut%0d addr%0d: data=%h valid=%b irq=%b, required %h/1/0",
                             d, a, rd_data[d], rd_valid[d], irq[d], expv);
                end
            end
        end
    endtask

    task automatic test_normal();
        do_reset();
        mask = 4'b0100;
        wr(2, 32'hDEAD_BEEF);
        tests++;
        if (irq !== 2'b11) begin
            fails++; $display("FAIL normal_irq_set: irq=%b, required 11", irq);
        end
        rd(3'd4);
        tests++;
        if (rd_data[0] !== 32'h4 || rd_data[1] !== 32'h4) begin
            fails++; $display("FAIL normal_status: %h %h, required 00000004", rd_data[0], rd_data[1]);
        end
        rd(3'd2);
        tests++;
        if (rd_data[0] !== 32'hDEAD_BEEF || irq[0] !== 1'b0) begin
            fails++; $display("FAIL normal_read: data=%h irq=%b, required deadbeef/0", rd_data[0], irq[0]);
        end
        tests++;
        if (rd_data[1] !== m_rd[1] || irq[1] !== m_irq[1]) begin
            fails++; $display("FAIL normal_read_snap: data=%h irq=%b, required %h/%b",
                              rd_data[1], irq[1], m_rd[1], m_irq[1]);
        end
        rd(3'd4);
        tests++;
        if (rd_data[0] !== 32'h0 || rd_data[1] !== m_rd[1]) begin
            fails++; $display("FAIL normal_status_after: %h %h, required 00000000 %h",
                              rd_data[0], rd_data[1], m_rd[1]);
        end
    endtask

    task automatic test_sticky();
        do_reset();
        mask = 4'b0010;
        wr(1, 32'h01);
        wr(1, 32'h80);
        rd(3'd4);
        tests++;
        if (rd_data[0] !== 32'h22 || rd_data[1] !== 32'h22) begin
            fails++; $display("FAIL sticky_status: %h %h, required 00000022", rd_data[0], rd_data[1]);
        end
        rd(3'd1);
        tests++;
        if (rd_data[0] !== 32'h81) begin
            fails++; $display("FAIL sticky_read: %h, required 00000081", rd_data[0]);
        end
        rd(3'd1);
        tests++;
        if (rd_data[0] !== RV0 || rd_data[1] !== m_rd[1]) begin
            fails++; $display("FAIL sticky_cleared: %h %h, required %h %h", rd_data[0], rd_data[1], RV0, m_rd[1]);
        end
    endtask

    task automatic test_snapshot();
        do_reset();
        mask = 4'hF;
        cycle(1'b0, 1'b0, 3'd0, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
        rd(3'd0);
        tests++;
        if (rd_data[1] !== 32'd1 || rd_data[0] !== 32'd1) begin
            fails++; $display("FAIL snap_ch0: %h %h, required 00000001", rd_data[0], rd_data[1]);
        end
        wr(3, 32'h99);
        rd(3'd3);
        tests++;
        if (rd_data[1] !== 32'd4 || rd_data[0] !== 32'h99) begin
            fails++; $display("FAIL snap_ch3: snap=%h live=%h, required 00000004 00000099", rd_data[1], rd_data[0]);
        end
        rd(3'd4);
        tests++;
        if (rd_data[1] !== 32'h8 || rd_data[0] !== m_rd[0]) begin
            fails++; $display("FAIL snap_status: snap=%h live=%h, required 00000008 %h", rd_data[1], rd_data[0], m_rd[0]);
        end
    endtask

    task automatic test_collision();
        do_reset();
        wr(1, 32'h0F);
        cycle(1'b1, 1'b1, 3'd1, 4'b0010, {32'h0, 32'h0, 32'h55, 32'h0});
        tests++;
        if (rd_data[0] !== 32'h0F) begin
            fails++; $display("FAIL collide_read: %h, required 0000000f", rd_data[0]);
        end
        rd(3'd4);
        tests++;
        if (rd_data[0] !== 32'h22) begin
            fails++; $display("FAIL collide_status: %h, required 00000022", rd_data[0]);
        end
        rd(3'd1);
        tests++;
        if (rd_data[0] !== 32'h55) begin
            fails++; $display("FAIL collide_next: %h, required 00000055", rd_data[0]);
        end
    endtask

    task automatic test_status_overrun();
        do_reset();
        wr(0, 32'h11);
        cycle(1'b1, 1'b1, 3'd4, 4'b0001, {96'h0, 32'h22});
        tests++;
        if (rd_data[0] !== 32'h01 || rd_data[1] !== 32'h01) begin
            fails++; $display("FAIL ovr_status1: %h %h, required 00000001", rd_data[0], rd_data[1]);
        end
        rd(3'd4);
        tests++;
        if (rd_data[0] !== 32'h11 || rd_data[1] !== 32'h11) begin
            fails++; $display("FAIL ovr_status2: %h %h, required 00000011", rd_data[0], rd_data[1]);
        end
        rd(3'd4);
        tests++;
        if (rd_data[0] !== 32'h01 || rd_data[1] !== 32'h01) begin
            fails++; $display("FAIL ovr_status3: %h %h, required 00000001", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mask = 4'hF;
        cycle(1'b0, 1'b0, 3'd0, 4'hF, {$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b1, 3'(k % 5), 4'($urandom) & 4'($urandom),
                  {$urandom, $urandom, $urandom, $urandom});
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (rd_valid[d] !== 1'b1 || rd_data[d] !== m_rd[d] || irq[d] !== m_irq[d]) begin
                    fails++;
                    $display("FAIL b2b dut%0d k%0d: data=%h valid=%b irq=%b, required %h/1/%b",
                             d, k, rd_data[d], rd_valid[d], irq[d], m_rd[d], m_irq[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] wd;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            mask = ($urandom_range(0, 9) == 0) ? 4'($urandom) : mask;
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < NC; i++) begin
                wd[i*32 +: 32] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 3'($urandom),
                  4'($urandom) & 4'($urandom), wd);
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (rd_valid[d] !== m_valid[d] || rd_data[d] !== m_rd[d] || irq[d] !== m_irq[d]) begin
                    fails++;
                    $display("FAIL random dut%0d k%0d: data=%h valid=%b irq=%b, required %h/%b/%b",
                             d, k, rd_data[d], rd_valid[d], irq[d], m_rd[d], m_valid[d], m_irq[d]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; rden = 1'b0; addr = '0; mask = '0; wdata = '0; wren = '0;
        model_reset();
        test_reset();
        test_normal();
        test_sticky();
        test_snapshot();
        test_collision();
        test_status_overrun();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/status_register_bank.md
# status_register_bank

Multi-channel, processor-read-only status register bank in the peripheral I/O space. I/O logic writes each channel; the processor reads channels, a flag/overrun status word, and an optional coherent snapshot of all channels. It generalises the single read-only register with configurable channel count, per-channel sticky (OR-accumulate) mode, read-clear new-data flags, overrun detection and a maskable interrupt. It has one clock domain, so it needs no handshaker.

## Interface
Parameters:
- DATA_WIDTH, 32, channel width; must be ≥ 2*NUM_CH.
- NUM_CH, 4, number of channels, 1..16.
- RESET_VALUE, '0, reset and clear value of every channel (DATA_WIDTH bits).
- STICKY_MASK, '0, NUM_CH bits; bit i=1 puts channel i in sticky mode.
- SNAPSHOT, 1, 1 = coherent snapshot reads, 0 = live reads.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-low
- Sys_RegSelect  in  1  bank selected by the address decoder
- Sys_RdEn  in  1  read strobe; a read is accepted when Sys_RegSelect & Sys_RdEn
- Sys_Addr  in  $clog2(NUM_CH+1)  word address
- Sys_RdData  out  DATA_WIDTH  registered read data
- Sys_RdValid  out  1  one-cycle pulse marking valid Sys_RdData
- Sys_IrqMask  in  NUM_CH  per-channel interrupt enable
- Sys_Irq  out  1  registered interrupt
- IO_WrData  in  NUM_CH*DATA_WIDTH  channel i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- IO_WrEn  in  NUM_CH  per-channel write strobe

## Operation
- Live[i] on IO_WrEn[i]:
  - Normal mode: Live[i] <= data.
  - Sticky mode: Live[i] <= Live[i] | data.
- New[i] is set on every write.
- Overrun[i] is set when a write arrives while New[i] is already 1.
- Address map:
  - addr < NUM_CH: channel data.
  - addr == NUM_CH: status word. Bits [NUM_CH-1:0] = New, bits [2*NUM_CH-1:NUM_CH] = Overrun, rest 0.
  - Any other address: 0.
- SNAPSHOT=0: a read of channel i returns Live[i] and clears New[i]; a sticky channel is also cleared to RESET_VALUE.
- SNAPSHOT=1:
  - A read of channel 0 returns Live[0] and copies every Live[j] into Shadow[j].
  - The same read clears all New flags and clears all sticky channels.
  - Reads of channels 1..NUM_CH-1 return Shadow[i] and change no state.
- A status read clears all Overrun flags. It does not clear New.
- Write and clear in the same cycle:
  - The write wins. New stays 1.
  - Read data and Shadow take the pre-write value.
  - A sticky channel loads RESET_VALUE | data, so no bits are lost.
- Write and status read in the same cycle: the status word shows the pre-write flags. An Overrun caused by that write stays set after the clear.
- Sys_Irq <= |(New & Sys_IrqMask), using next-state New.
- Unaccepted cycles: Sys_RdData holds its value and Sys_RdValid = 0.

## Timing
- Read latency is 1 cycle: a read accepted at edge k gives Sys_RdData/Sys_RdValid valid after edge k+1. Back-to-back reads are accepted every cycle.
- Write to Live visibility is 1 cycle. A write at edge k is readable by a read accepted at edge k+1.
- Sys_Irq asserts 1 cycle after the flag-setting write and deasserts 1 cycle after the clearing read.
- Reset low at an edge sets:
  - Live = Shadow = RESET_VALUE.
  - New = Overrun = 0.
  - Sys_RdData = 0, Sys_RdValid = 0, Sys_Irq = 0.
- Reset mid-read drops the pending Sys_RdValid.
- Reset dominates every write and read in the same cycle.

## Structure
- Package status_bank_pkg holds:
  - Address-width function and status-word field offsets.
  - Channel mode enum: CH_NORMAL, CH_STICKY.
- Sub-module status_channel: one channel's Live register, New/Overrun flags and sticky/clear logic, instantiated NUM_CH times by generate.
- The top level holds the address decode, Shadow array, read mux, output registers and IRQ.

## Test plan
- Reset release: read every address, expect RESET_VALUE for channels, 0 for status, Sys_Irq=0.
- Normal channel: write ch2=0xDEADBEEF. Expect status 0x0004 and Sys_Irq=1 if mask bit 2 is set. Read ch2, expect 0xDEADBEEF, then status 0x0000 and Sys_Irq=0.
- Sticky channel (STICKY_MASK=4'b0010): write ch1=0x01 then 0x80. Expect status 0x0022 (New[1] and Overrun[1]). Read, expect 0x81, then read again, expect RESET_VALUE.
- Snapshot: write ch0..3=1..4 and read ch0. Then write ch3=0x99 and read ch3, expect 4 (Shadow). Status shows New[3]=1 only.
- Collision: write ch1=0x55 in the same cycle as the ch1 read (SNAPSHOT=0). The read returns the old value, New[1] stays 1, and the next read returns 0x55.
- Status clear with simultaneous overrun: both cycles are on ch0 with SNAPSHOT=0.
  - Cycle 1: write ch0=0x11, no read; New[0] sets.
  - Cycle 2: write ch0=0x22 in the same cycle as the status read. The read returns 0x0001. Overrun[0] stays set, so the next status read returns 0x0011.
